// File: rtl/frame_fsm_monitor.sv
// Frame FSM monitor: watches an externally generated frame FSM state and its
// frame counter, flags illegal transitions, count-gate violations, counter
// discontinuities and dwell timeouts, and keeps a sticky first-error capture
// plus a saturating error total.
module frame_fsm_monitor #(
   parameter int COUNT_W   = 6,
   parameter int FRAME_LEN = 40,
   parameter int WR_END    = 17,
   parameter int RD_END    = 35,
   parameter int LOAD_AT   = 39,
   parameter int MAX_DWELL = 64,
   parameter int ERRCNT_W  = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [COUNT_W-1:0]  i_count,
   input  logic [2:0]          i_state,
   input  logic                i_clear,
   output logic                o_errPulse,
   output logic                o_errValid,
   output logic [2:0]          o_errCode,
   output logic [2:0]          o_errPrevState,
   output logic [2:0]          o_errCurState,
   output logic [COUNT_W-1:0]  o_errCount,
   output logic [ERRCNT_W-1:0] o_errTotal
);

   typedef enum logic [2:0] {
      ST_INIT         = 3'd0,
      ST_LOAD_COMMAND = 3'd1,
      ST_START_FRAME  = 3'd2,
      ST_WRC_LOW      = 3'd3,
      ST_WRC_HIGH     = 3'd4,
      ST_END_FRAME    = 3'd5,
      ST_RDC_LOW      = 3'd6,
      ST_RDC_HIGH     = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_ILLEGAL = 3'd1,
      ERR_GATE    = 3'd2,
      ERR_DISCONT = 3'd3,
      ERR_DWELL   = 3'd4
   } err_code_t;

   localparam int                  DWELL_W   = $clog2(MAX_DWELL + 1);
   localparam logic [DWELL_W-1:0]  LP_DWELL  = DWELL_W'(MAX_DWELL);
   localparam logic [COUNT_W-1:0]  LP_LAST   = COUNT_W'(FRAME_LEN - 1);
   localparam logic [COUNT_W:0]    LP_LEN    = (COUNT_W + 1)'(FRAME_LEN);
   localparam logic [COUNT_W-1:0]  LP_WR_END = COUNT_W'(WR_END);
   localparam logic [COUNT_W-1:0]  LP_RD_END = COUNT_W'(RD_END);
   localparam logic [COUNT_W-1:0]  LP_LOAD   = COUNT_W'(LOAD_AT);

   state_t             r_prev_state;
   logic [COUNT_W-1:0] r_prev_count;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_primed;

   state_t             w_cur_state;
   logic               w_changed;
   logic               w_legal;
   logic               w_gate_ok;
   logic [COUNT_W-1:0] w_exp_count;
   logic               w_discont;
   logic [DWELL_W-1:0] w_dwell_next;
   logic               w_timeout;
   err_code_t          w_code;

   assign w_cur_state = state_t'(i_state);

   // Classify the current sample against the registered previous sample.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_legal   = 1'b0;
      w_gate_ok = 1'b1;
      w_changed = (w_cur_state != r_prev_state);

      case (r_prev_state)
         ST_INIT, ST_END_FRAME: begin
            if (w_cur_state == ST_LOAD_COMMAND) begin
               w_legal   = 1'b1;
               w_gate_ok = (r_prev_count == LP_LOAD);
            end
         end
         ST_LOAD_COMMAND: w_legal = (w_cur_state == ST_START_FRAME);
         ST_START_FRAME:  w_legal = (w_cur_state == ST_WRC_LOW);
         ST_WRC_LOW:      w_legal = (w_cur_state == ST_WRC_HIGH);
         ST_WRC_HIGH: begin
            if (w_cur_state == ST_WRC_LOW) begin
               w_legal   = 1'b1;
               w_gate_ok = (r_prev_count != LP_WR_END);
            end else if (w_cur_state == ST_RDC_LOW) begin
               w_legal   = 1'b1;
               w_gate_ok = (r_prev_count == LP_WR_END);
            end
         end
         ST_RDC_LOW:      w_legal = (w_cur_state == ST_RDC_HIGH);
         ST_RDC_HIGH: begin
            if (w_cur_state == ST_RDC_LOW) begin
               w_legal   = 1'b1;
               w_gate_ok = (r_prev_count != LP_RD_END);
            end else if (w_cur_state == ST_END_FRAME) begin
               w_legal   = 1'b1;
               w_gate_ok = (r_prev_count == LP_RD_END);
            end
         end
         default: ;
      endcase

      w_exp_count = (r_prev_count == LP_LAST) ? '0 : r_prev_count + COUNT_W'(1);
      w_discont   = (i_count != w_exp_count) || ({1'b0, i_count} >= LP_LEN);

      // Dwell counts samples spent in the current state; a change restarts at 1.
      if (w_changed)
         w_dwell_next = DWELL_W'(1);
      else if (r_dwell == LP_DWELL)
         w_dwell_next = r_dwell;
      else
         w_dwell_next = r_dwell + DWELL_W'(1);

      // Only the first arrival at the limit is reported, not the saturated hold.
      w_timeout = (w_dwell_next == LP_DWELL) && (r_dwell != LP_DWELL);

      // Lowest code wins when several checks fail on the same sample.
      w_code = ERR_NONE;
      if (r_primed) begin
         if (w_changed && !w_legal)
            w_code = ERR_ILLEGAL;
         else if (w_changed && !w_gate_ok)
            w_code = ERR_GATE;
         else if (w_discont)
            w_code = ERR_DISCONT;
         else if (w_timeout)
            w_code = ERR_DWELL;
      end
   end

   // Sample history, dwell counter and the post-reset priming flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_state <= ST_INIT;
         r_prev_count <= '0;
         r_dwell      <= '0;
         r_primed     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         r_prev_state <= w_cur_state;
         r_prev_count <= i_count;
         r_dwell      <= w_dwell_next;
         r_primed     <= 1'b1;
      end
   end

   // Error pulse, sticky first-error capture and saturating total.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_errPulse     <= 1'b0;
         o_errValid     <= 1'b0;
         o_errCode      <= '0;
         o_errPrevState <= '0;
         o_errCurState  <= '0;
         o_errCount     <= '0;
         o_errTotal     <= '0;
      end else begin
         o_errPulse <= (w_code != ERR_NONE);
         if (i_clear) begin
            // A clear wipes history; an error on the same sample starts it afresh.
            o_errValid     <= (w_code != ERR_NONE);
            o_errCode      <= (w_code != ERR_NONE) ? w_code       : 3'd0;
            o_errPrevState <= (w_code != ERR_NONE) ? r_prev_state : 3'd0;
            o_errCurState  <= (w_code != ERR_NONE) ? i_state      : 3'd0;
            o_errCount     <= (w_code != ERR_NONE) ? r_prev_count : '0;
            o_errTotal     <= (w_code != ERR_NONE) ? ERRCNT_W'(1) : '0;
         end else if (w_code != ERR_NONE) begin
            if (!o_errValid) begin
               o_errValid     <= 1'b1;
               o_errCode      <= w_code;
               o_errPrevState <= r_prev_state;
               o_errCurState  <= i_state;
               o_errCount     <= r_prev_count;
            end
            if (!(&o_errTotal))
               o_errTotal <= o_errTotal + ERRCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_frame_fsm_monitor.sv
// Directed bench for frame_fsm_monitor: legal frames, each error class,
// priority, dwell timeout, total saturation, clear and mid-frame reset.
module tb_frame_fsm_monitor;

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WRL   = 3'd3;
   localparam logic [2:0] S_WRH   = 3'd4;
   localparam logic [2:0] S_END   = 3'd5;
   localparam logic [2:0] S_RDL   = 3'd6;
   localparam logic [2:0] S_RDH   = 3'd7;

   logic       clk;
   logic       rst_n;
   logic [5:0] i_count;
   logic [2:0] i_state;
   logic       i_clear;
   logic       o_errPulse;
   logic       o_errValid;
   logic [2:0] o_errCode;
   logic [2:0] o_errPrevState;
   logic [2:0] o_errCurState;
   logic [5:0] o_errCount;
   logic [7:0] o_errTotal;

   int n_vec = 0;
   int n_err = 0;

   frame_fsm_monitor dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_count        (i_count),
      .i_state        (i_state),
      .i_clear        (i_clear),
      .o_errPulse     (o_errPulse),
      .o_errValid     (o_errValid),
      .o_errCode      (o_errCode),
      .o_errPrevState (o_errPrevState),
      .o_errCurState  (o_errCurState),
      .o_errCount     (o_errCount),
      .o_errTotal     (o_errTotal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one sample, let it be clocked in, return 1 time unit after the edge.
   task automatic apply(input logic [2:0] st, input int cnt, input logic clr);
      i_state = st;
      i_count = 6'(cnt);
      i_clear = clr;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
   endtask

   function automatic logic [2:0] frame_state(input int c);
      if (c == 0)       return S_LOAD;
      else if (c == 1)  return S_START;
      else if (c <= 17) return (c % 2 == 0) ? S_WRL : S_WRH;
      else if (c <= 35) return (c % 2 == 0) ? S_RDL : S_RDH;
      else              return S_END;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".pulse"}, 32'(o_errPulse), 0);
      check({tag, ".valid"}, 32'(o_errValid), 0);
      check({tag, ".code"},  32'(o_errCode), 0);
      check({tag, ".prev"},  32'(o_errPrevState), 0);
      check({tag, ".cur"},   32'(o_errCurState), 0);
      check({tag, ".count"}, 32'(o_errCount), 0);
      check({tag, ".total"}, 32'(o_errTotal), 0);
   endtask

   initial begin
      int pulses;
      int pulse_at;
      int pulse_code;

      rst_n   = 1'b0;
      i_state = S_INIT;
      i_count = '0;
      i_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Three legal frames preceded by an INIT pass through counts 0..39.
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         apply(S_INIT, c, 1'b0);
         if (o_errPulse) pulses++;
      end
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 40; c++) begin
            apply(frame_state(c), c, 1'b0);
            if (o_errPulse) pulses++;
         end
      end
      check("legal.pulses", 32'(pulses), 0);
      check("legal.total", 32'(o_errTotal), 0);
      check("legal.valid", 32'(o_errValid), 0);

      // Set up WRC_HIGH at count 16, clearing the setup error on a clean sample.
      apply(S_WRH, 15, 1'b0);
      check("setup.pulse", 32'(o_errPulse), 1);
      check("setup.code", 32'(o_errCode), 1);
      apply(S_WRH, 16, 1'b1);
      check("clear.valid", 32'(o_errValid), 0);
      check("clear.total", 32'(o_errTotal), 0);
      check("clear.code", 32'(o_errCode), 0);

      // Early exit to RDC_LOW: count gate violation.
      apply(S_RDL, 17, 1'b0);
      check("gate.pulse", 32'(o_errPulse), 1);
      check("gate.code", 32'(o_errCode), 2);
      check("gate.prev", 32'(o_errPrevState), 4);
      check("gate.cur", 32'(o_errCurState), 6);
      check("gate.count", 32'(o_errCount), 16);
      check("gate.total", 32'(o_errTotal), 1);
      apply(S_RDH, 18, 1'b0);
      check("gate.pulse_end", 32'(o_errPulse), 0);

      // Illegal transition together with a count jump: illegal wins.
      apply(S_START, 19, 1'b0);
      apply(S_START, 4, 1'b0);
      apply(S_START, 5, 1'b1);
      check("prio.cleared", 32'(o_errTotal), 0);
      apply(S_RDH, 9, 1'b0);
      check("prio.pulse", 32'(o_errPulse), 1);
      check("prio.code", 32'(o_errCode), 1);
      check("prio.prev", 32'(o_errPrevState), 2);
      check("prio.cur", 32'(o_errCurState), 7);
      check("prio.count", 32'(o_errCount), 5);
      check("prio.total", 32'(o_errTotal), 1);

      // Hold LOAD_COMMAND for 70 samples: one dwell timeout on the 64th.
      apply(S_LOAD, 10, 1'b0);
      pulses     = 0;
      pulse_at   = -1;
      pulse_code = 0;
      for (int k = 1; k < 70; k++) begin
         apply(S_LOAD, (10 + k) % 40, (k == 1));
         if (o_errPulse) begin
            pulses++;
            pulse_at   = k;
            pulse_code = 32'(o_errCode);
         end
      end
      check("dwell.pulses", 32'(pulses), 1);
      check("dwell.at", 32'(pulse_at), 63);
      check("dwell.code", 32'(pulse_code), 4);
      check("dwell.count", 32'(o_errCount), 32);
      check("dwell.total", 32'(o_errTotal), 1);

      // 300 discontinuities saturate the total; first capture is retained.
      for (int k = 0; k < 300; k++) apply(S_LOAD, 5, 1'b0);
      check("sat.total", 32'(o_errTotal), 255);
      check("sat.code", 32'(o_errCode), 4);
      check("sat.count", 32'(o_errCount), 32);
      apply(S_LOAD, 5, 1'b0);
      check("sat.hold", 32'(o_errTotal), 255);
      check("sat.pulse", 32'(o_errPulse), 1);

      // Clear coinciding with an error captures it fresh.
      apply(S_LOAD, 5, 1'b1);
      check("clrerr.total", 32'(o_errTotal), 1);
      check("clrerr.valid", 32'(o_errValid), 1);
      check("clrerr.code", 32'(o_errCode), 3);
      check("clrerr.prev", 32'(o_errPrevState), 1);
      check("clrerr.cur", 32'(o_errCurState), 1);
      check("clrerr.count", 32'(o_errCount), 5);

      // Mid-frame asynchronous reset.
      apply(S_LOAD, 5, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      apply(S_WRL, 23, 1'b0);
      check("unprimed.pulse", 32'(o_errPulse), 0);
      check("unprimed.total", 32'(o_errTotal), 0);
      check("unprimed.valid", 32'(o_errValid), 0);
      apply(S_WRL, 24, 1'b0);
      check("primed.clean", 32'(o_errPulse), 0);
      apply(S_RDH, 25, 1'b0);
      check("primed.pulse", 32'(o_errPulse), 1);
      check("primed.code", 32'(o_errCode), 1);
      check("primed.prev", 32'(o_errPrevState), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_fsm_monitor.md
FRAME_FSM_MONITOR -- requirements
Module: frame_fsm_monitor

Interface
REQ-001 SHALL have parameter COUNT_W, default 6, meaning width of the frame counter input.
REQ-002 SHALL have parameter FRAME_LEN, default 40, meaning the counter modulus; legal counts are 0..FRAME_LEN-1.
REQ-003 SHALL have parameter WR_END, default 17, meaning the previous count that gates WRC_HIGH->RDC_LOW.
REQ-004 SHALL have parameter RD_END, default 35, meaning the previous count that gates RDC_HIGH->END_FRAME.
REQ-005 SHALL have parameter LOAD_AT, default 39, meaning the previous count that gates INIT/END_FRAME->LOAD_COMMAND.
REQ-006 SHALL have parameter MAX_DWELL, default 64, meaning the maximum number of consecutive cycles in one state before a timeout.
REQ-007 SHALL have parameter ERRCNT_W, default 8, meaning the width of the saturating error total.
REQ-008 SHALL have ports: i_clk in 1 (clock); i_rst_n in 1 (reset); i_count in COUNT_W (observed frame counter); i_state in 3 (observed FSM state); i_clear in 1 (clear the capture and total).
REQ-009 SHALL have ports: o_errPulse out 1 (error this cycle); o_errValid out 1 (sticky capture valid); o_errCode out 3; o_errPrevState out 3; o_errCurState out 3; o_errCount out COUNT_W (captured previous count); o_errTotal out ERRCNT_W.
REQ-010 SHALL use one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-011 SHALL use state encoding INIT=0, LOAD_COMMAND=1, START_FRAME=2, WRC_LOW=3, WRC_HIGH=4, END_FRAME=5, RDC_LOW=6, RDC_HIGH=7.

Function
REQ-012 SHALL register i_state and i_count every cycle as prevState and prevCount; all checks compare the current inputs against these registers.
REQ-013 SHALL hold a primed flag that is 0 out of reset, is set on the first clock after reset, and suppresses all checks while 0.
REQ-014 SHALL accept a self-loop for every state.
REQ-015 SHALL accept only these state changes: INIT->LOAD_COMMAND; LOAD_COMMAND->START_FRAME; START_FRAME->WRC_LOW; WRC_LOW->WRC_HIGH; WRC_HIGH->WRC_LOW; WRC_HIGH->RDC_LOW; RDC_LOW->RDC_HIGH; RDC_HIGH->RDC_LOW; RDC_HIGH->END_FRAME; END_FRAME->LOAD_COMMAND.
REQ-016 SHALL flag code 1 (illegal transition) for any other state change.
REQ-017 SHALL flag code 2 (count gate) for a legal change that violates its count gate: INIT or END_FRAME->LOAD_COMMAND requires prevCount==LOAD_AT; WRC_HIGH->RDC_LOW requires prevCount==WR_END; WRC_HIGH->WRC_LOW requires prevCount!=WR_END; RDC_HIGH->END_FRAME requires prevCount==RD_END; RDC_HIGH->RDC_LOW requires prevCount!=RD_END.
REQ-018 SHALL flag code 3 (counter discontinuity) when i_count is not equal to (prevCount+1) mod FRAME_LEN, or when i_count>=FRAME_LEN.
REQ-019 SHALL keep a dwell counter that resets to 1 on a state change, increments on a self-loop, and saturates at MAX_DWELL.
REQ-020 SHALL flag code 4 (dwell timeout) once, on the cycle the dwell counter first reaches MAX_DWELL; it does not flag again until the state changes.
REQ-021 SHALL resolve simultaneous errors by priority, lowest code first; the cycle counts as one error.
REQ-022 SHALL assert o_errPulse for exactly one cycle, registered, on the edge after the offending sample; latency from sample to output is 1 cycle.
REQ-023 SHALL capture code, prevState, i_state and prevCount into the o_err* outputs on the first error only while o_errValid==0, and set o_errValid sticky.
REQ-024 SHALL increment o_errTotal once per error cycle and saturate at all-ones.
REQ-025 SHALL, on i_clear, zero o_errValid, the capture fields and o_errTotal; an error in the same cycle as i_clear is captured fresh, giving o_errValid=1 and o_errTotal=1.

Reset
REQ-026 SHALL, on asserted i_rst_n, asynchronously force all outputs to 0, primed to 0, prevState to INIT, prevCount to 0 and the dwell counter to 0, including mid-frame.

Verification
REQ-027 Drive a legal frame loop (INIT to LOAD at count 0 after 39, WRC/RDC toggling, END_FRAME at 36, LOAD at 0) for 3 frames -> o_errPulse never 1, o_errTotal=0.
REQ-028 With prevState=WRC_HIGH and prevCount=16, drive RDC_LOW -> one cycle later o_errPulse=1, o_errCode=2, o_errPrevState=4, o_errCurState=6, o_errCount=16.
REQ-029 Drive START_FRAME->RDC_HIGH while the count also jumps 5->9 -> o_errCode=1 (priority), o_errTotal=1.
REQ-030 Hold LOAD_COMMAND for 70 cycles with a legal count -> exactly one code-4 pulse, on the sample where dwell reaches 64.
REQ-031 Inject 300 discontinuity errors -> o_errTotal=255 and holds; the capture retains the first error; i_clear with a simultaneous error -> o_errTotal=1, new capture.
REQ-032 Assert i_rst_n low mid-frame, then release -> all outputs 0; the first post-reset sample raises no error regardless of its state or count.
